// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multi-cycle multiply/divide sequencer holding the HI/LO pair.
// Sits in Execute beside the ALU. One md operation is accepted per start pulse
// while idle. A down-counter models the fixed MULT/DIV latency. The result is
// computed from operands latched at the start edge and lands in HI/LO on the
// edge where the counter reaches zero. The stall request is purely
// combinational so the hazard unit can freeze Decode in the start cycle itself.

module mult_div_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Operation encoding used on the op input and in the latched copy.
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    // Sequencer states: waiting for work, or counting down a computation.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Latency values. The counter is 4 bits because both latencies are at
    // most 15 cycles.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    md_state_e   r_state;
    md_state_e   w_nextState;
    logic [3:0]  r_count;
    md_op_e      r_op;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    md_op_e      w_opIn;
    logic        w_isIdle;
    logic        w_isBusy;
    logic        w_isMulDiv;
    logic        w_launch;
    logic        w_writeHi;
    logic        w_writeLo;
    logic        w_finish;

    logic [63:0] w_mulA;
    logic [63:0] w_mulB;
    logic [63:0] w_product;

    logic        w_divSigned;
    logic        w_dividendNeg;
    logic        w_divisorNeg;
    logic        w_divByZero;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [32:0] w_remAcc;
    logic [31:0] w_uQuot;
    logic [31:0] w_uRem;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    logic [31:0] w_hiNext;
    logic [31:0] w_loNext;

    // Decode the incoming request. Only an idle unit accepts work, so a start
    // that arrives while busy changes nothing.
    always_comb begin
        w_opIn     = md_op_e'(op);
        w_isIdle   = (r_state == ST_IDLE);
        w_isBusy   = (r_state == ST_BUSY);
        w_isMulDiv = (w_opIn == OP_MULT) || (w_opIn == OP_MULTU) ||
                     (w_opIn == OP_DIV)  || (w_opIn == OP_DIVU);
        w_launch   = start && w_isIdle && w_isMulDiv;
        w_writeHi  = start && w_isIdle && (w_opIn == OP_MTHI);
        w_writeLo  = start && w_isIdle && (w_opIn == OP_MTLO);
        w_finish   = w_isBusy && (r_count == 4'd1);
    end

    // State register for the idle/busy sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: leave idle on an accepted mul/div, return on the last count.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_nextState = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_finish) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Latency counter and operand latch. Operands are captured at the start
    // edge so later changes on the forwarding paths cannot disturb the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 4'd0;
            r_op    <= OP_NONE;
            r_opA   <= 32'd0;
            r_opB   <= 32'd0;
        end else if (w_launch) begin
            r_count <= ((w_opIn == OP_MULT) || (w_opIn == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
            r_op    <= w_opIn;
            r_opA   <= srcA;
            r_opB   <= srcB;
        end else if (w_isBusy && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    // Multiplier: extend both operands to 64 bits (sign or zero per op); the
    // low 64 bits of the product are then correct for either signedness.
    always_comb begin
        if (r_op == OP_MULT) begin
            w_mulA = {{32{r_opA[31]}}, r_opA};
            w_mulB = {{32{r_opB[31]}}, r_opB};
        end else begin
            w_mulA = {32'd0, r_opA};
            w_mulB = {32'd0, r_opB};
        end
        w_product = w_mulA * w_mulB;
    end

    // Divider front end: signed division is done on magnitudes and the signs
    // are fixed up afterwards. The magnitude of 0x80000000 is itself as an
    // unsigned value, which makes the 0x80000000 / -1 case fall out naturally.
    always_comb begin
        w_divSigned   = (r_op == OP_DIV);
        w_dividendNeg = w_divSigned && r_opA[31];
        w_divisorNeg  = w_divSigned && r_opB[31];
        w_divByZero   = (r_opB == 32'd0);
        w_absA        = w_dividendNeg ? (32'd0 - r_opA) : r_opA;
        w_absB        = w_divisorNeg  ? (32'd0 - r_opB) : r_opB;
    end

    // Unsigned restoring divider, one quotient bit per step, MSB first.
    always_comb begin
        w_remAcc = 33'd0;
        w_uQuot  = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            w_remAcc = {w_remAcc[31:0], w_absA[i]};
            if (w_remAcc >= {1'b0, w_absB}) begin
                w_remAcc   = w_remAcc - {1'b0, w_absB};
                w_uQuot[i] = 1'b1;
            end
        end
        w_uRem = w_remAcc[31:0];
    end

    // Sign fix-up: the quotient truncates toward zero and the remainder
    // follows the sign of the dividend.
    always_comb begin
        w_quot = (w_dividendNeg ^ w_divisorNeg) ? (32'd0 - w_uQuot) : w_uQuot;
        w_rem  = w_dividendNeg ? (32'd0 - w_uRem) : w_uRem;
    end

    // HI/LO next values: results land on the final count, and moves write
    // immediately. A zero divisor leaves HI/LO untouched.
    always_comb begin
        w_hiNext = r_hi;
        w_loNext = r_lo;
        if (w_finish) begin
            case (r_op)
                OP_MULT, OP_MULTU: begin
                    w_hiNext = w_product[63:32];
                    w_loNext = w_product[31:0];
                end
                OP_DIV, OP_DIVU: begin
                    if (!w_divByZero) begin
                        w_hiNext = w_rem;
                        w_loNext = w_quot;
                    end
                end
                default: begin
                    w_hiNext = r_hi;
                    w_loNext = r_lo;
                end
            endcase
        end
        if (w_writeHi) begin
            w_hiNext = srcA;
        end
        if (w_writeLo) begin
            w_loNext = srcA;
        end
    end

    // HI/LO registers. Reset clears them and discards any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            r_hi <= w_hiNext;
            r_lo <= w_loNext;
        end
    end

    // Outputs. The stall covers the start cycle and every busy cycle, so an md
    // instruction in Decode waits without a register stage of delay.
    always_comb begin
        busy     = w_isBusy;
        stall_md = md_use_d & (start | w_isBusy);
        hi       = r_hi;
        lo       = r_lo;
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: table-driven bench with a scoreboard queue for mult_div_ctrl.

module tb_mult_div_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expBusy;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busyCycles;
        int          stallCycles;
    } exp_t;

    vec_t vecs[16];
    exp_t sbQueue[$];

    int vectorCount;
    int missCount;
    int obsBusy;
    int obsStall;
    bit timedOut;

    mult_div_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .srcA    (srcA),
        .srcB    (srcB),
        .md_use_d(md_use_d),
        .busy    (busy),
        .stall_md(stall_md),
        .hi      (hi),
        .lo      (lo)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol guard: the hazard unit must never issue start while busy.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(start && busy)) else $error("[TB] start asserted while busy");
        end
    end

    // One comparison: counts it and reports a miscompare.
    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one start pulse, queue the expected outcome, then follow the busy
    // window while counting busy and stall cycles.
    task automatic applyStimulus(input vec_t v, input logic useD);
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        op       = v.op;
        srcA     = v.a;
        srcB     = v.b;
        md_use_d = useD;
        e.hi          = v.expHi;
        e.lo          = v.expLo;
        e.busyCycles  = v.expBusy;
        e.stallCycles = useD ? v.expBusy + 1 : 0;
        sbQueue.push_back(e);
        #1;
        obsBusy  = 0;
        obsStall = (stall_md === 1'b1) ? 1 : 0;
        timedOut = 1'b0;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        srcA  = $urandom;
        srcB  = $urandom;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (busy !== 1'b1) break;
            obsBusy++;
            if (stall_md === 1'b1) obsStall++;
            @(negedge clk);
            #1;
        end
        if (busy === 1'b1) timedOut = 1'b1;
    endtask

    // Pop the oldest expectation and compare it against the idle-cycle outputs.
    task automatic checkOutput(input int idx);
        exp_t e;
        string tag;
        tag = $sformatf("vec%0d", idx);
        vectorCount++;
        if (sbQueue.size() == 0) begin
            missCount++;
            $display("[TB] FAIL %s scoreboard: queue empty, expected an entry", tag);
            return;
        end
        e = sbQueue.pop_front();
        vectorCount++;
        if (timedOut) begin
            missCount++;
            $display("[TB] FAIL %s timeout: busy still 1 after 40 cycles, expected 0", tag);
        end
        checkVal({tag, " hi"}, hi, e.hi);
        checkVal({tag, " lo"}, lo, e.lo);
        checkVal({tag, " busyCycles"}, 32'(obsBusy), 32'(e.busyCycles));
        checkVal({tag, " stallCycles"}, 32'(obsStall), 32'(e.stallCycles));
        checkVal({tag, " stallIdle"}, {31'd0, stall_md}, 32'd0);
    endtask

    initial begin
        // Vectors run in order; expectations for moves, ignored ops and
        // divide-by-zero depend on the HI/LO left by earlier entries.
        vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd4, 32'h00001234, 32'h00000000, 32'h00000001, 32'h00000003, 10};
        vecs[5]  = '{3'd5, 32'h12345678, 32'h0000DEAD, 32'h12345678, 32'h00000003, 0};
        vecs[6]  = '{3'd6, 32'h0000ABCD, 32'h0000BEEF, 32'h12345678, 32'h0000ABCD, 0};
        vecs[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[8]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[9]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[10] = '{3'd3, 32'hFFFFFFF9, 32'h00000000, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[11] = '{3'd0, 32'h11111111, 32'h22222222, 32'h00000001, 32'hFFFFFFFD, 0};
        vecs[12] = '{3'd7, 32'h33333333, 32'h44444444, 32'h00000001, 32'hFFFFFFFD, 0};
        vecs[13] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[14] = '{3'd4, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 10};
        vecs[15] = '{3'd3, 32'h80000000, 32'h00000003, 32'hFFFFFFFE, 32'hD5555556, 10};

        vectorCount = 0;
        missCount   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        srcA     = 32'd0;
        srcB     = 32'd0;
        md_use_d = 1'b1;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("reset busy", {31'd0, busy}, 32'd0);
        checkVal("reset hi", hi, 32'd0);
        checkVal("reset lo", lo, 32'd0);
        checkVal("reset stall", {31'd0, stall_md}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], (i % 3) != 2);
            checkOutput(i);
        end

        // Reset during busy cycle 3 of a DIV discards the in-flight result.
        @(negedge clk);
        start    = 1'b1;
        op       = 3'd3;
        srcA     = 32'd100;
        srcB     = 32'd7;
        md_use_d = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        #1;
        checkVal("midreset busy1", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        #1;
        checkVal("midreset busy3", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("midreset busy", {31'd0, busy}, 32'd0);
        checkVal("midreset hi", hi, 32'd0);
        checkVal("midreset lo", lo, 32'd0);
        checkVal("midreset stall", {31'd0, stall_md}, 32'd0);
        start = 1'b1;
        op    = 3'd0;
        #1;
        checkVal("midreset stallStart", {31'd0, stall_md}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        obsBusy = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (busy === 1'b1) obsBusy++;
            @(negedge clk);
        end
        checkVal("midreset busyAfter", 32'(obsBusy), 32'd0);
        checkVal("midreset hiAfter", hi, 32'd0);
        checkVal("midreset loAfter", lo, 32'd0);
        checkVal("scoreboard drained", 32'(sbQueue.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Multi-cycle multiply/divide sequencer with the HI/LO register pair. It sits in the Execute stage, beside the ALU.
- It accepts one md operation per start pulse, models the fixed MULT/DIV latency with a down-counter, and holds results in HI/LO.
- It raises a stall request that the hazard unit ORs into EnPC/EnIFID/EnIDEX/FlushIDEX, so md instructions in Decode wait while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse from Execute: md instruction in E qualifies op
- op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved
- srcA  input  32  forwarded rs value (FwdE1 path)
- srcB  input  32  forwarded rt value (FwdE2 path)
- md_use_d  input  1  instruction in Decode is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
- busy  output  1  computation in progress
- stall_md  output  1  stall request to the hazard unit
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset, sampled on posedge clk with reset=1: busy=0, counter=0, hi=0, lo=0, latched operands=0, pending op=NONE. Reset wins over every other event, including a reset arriving mid-operation; the in-flight result is discarded.
- Idle (busy=0), start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch srcA, srcB and op at the edge.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- Busy: the counter decrements each edge. On the edge where the counter goes 1->0, write hi/lo and set busy=0. busy is high for exactly N cycles after the start edge; new hi/lo are visible in the first cycle with busy=0.
- Idle, start=1, op=MTHI: hi<=srcA at that edge; busy stays 0.
- Idle, start=1, op=MTLO: lo<=srcA at that edge; busy stays 0.
- start=1 while busy=1: ignored, no state change. The hazard unit must prevent this; the verifier flags it with an assertion.
- op NONE or reserved with start=1: ignored.
- MULT: signed 32x32 to 64-bit product; hi=product[63:32], lo=product[31:0].
- MULTU: same as MULT, unsigned.
- DIV: signed, truncates toward zero. lo=quotient; remainder takes the sign of the dividend, in hi.
- DIVU: unsigned; lo=quotient, hi=remainder.
- Divisor 0 (DIV or DIVU): busy runs its full duration, then hi and lo are left unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Results are computed from the latched operands. srcA/srcB may change after the start edge with no effect.
- stall_md = md_use_d & (start | busy). Purely combinational, no register stage. It holds the md instruction in Decode for the start cycle plus every busy cycle.
- hi/lo are read directly by MFHI/MFLO in Execute. The combinational stall guarantees no read occurs while busy=1.

Test Plan:
- Reset, then MULT srcA=0xFFFFFFFD (-3), srcB=5 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- MULTU srcA=0xFFFFFFFF, srcB=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. Change srcA during busy -> result unaffected.
- DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU srcA=7, srcB=2 -> lo=3, hi=1. Then DIVU with srcB=0 -> busy for 10 cycles, then hi=1, lo=3 unchanged.
- MTHI srcA=0x12345678 -> next cycle hi=0x12345678, busy never 1. MTLO srcA=0xABCD -> lo=0x0000ABCD.
- start MULT, md_use_d=1 throughout -> stall_md=1 on the start cycle and all 5 busy cycles, 0 afterwards.
- Reset at busy cycle 3 of a DIV -> next cycle busy=0, hi=lo=0, stall_md=md_use_d&start.
